// File: rtl/fb_write_bridge.sv
// CPU store to framebuffer bridge: decodes MMIO stores into a command FIFO and
// turns them into single pixel writes, full-frame fill sweeps and dump beats.
module fb_write_bridge #(
    parameter int FRAME_WIDTH  = 320,
    parameter int FRAME_HEIGHT = 240,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [19:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_err,
    output logic        busy,
    output logic        fb_valid,
    input  logic        fb_ready,
    output logic [16:0] fb_address,
    output logic [23:0] fb_data,
    output logic        fb_operation,
    output logic        fb_dump
);
    localparam int          NPIX     = FRAME_WIDTH * FRAME_HEIGHT;
    localparam logic [19:0] CTRL_OFF = 20'(NPIX * 4);
    localparam logic [19:0] FILL_OFF = 20'(NPIX * 4 + 4);
    localparam logic [16:0] LAST_IDX = 17'(NPIX - 1);
    localparam int          AW       = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {K_PIXEL, K_CTRL, K_FILL} kind_t;
    typedef struct packed {
        kind_t       kind;
        logic [16:0] idx;
        logic [23:0] data;
    } cmd_t;
    typedef enum logic [1:0] {IDLE, ISSUE, SWEEP, DUMP} state_t;

    state_t      state;
    cmd_t        mem [FIFO_DEPTH];
    cmd_t        req_cmd, head;
    logic [AW:0] wptr, rptr;
    logic        addr_ok, push, pop, fifo_empty, fifo_full;
    logic [23:0] fill_color;
    logic        sweep_dump;
    logic        unused_wdata;

    assign unused_wdata = ^req_wdata[31:24];

    always_comb begin
        req_cmd.idx  = req_addr[18:2];
        req_cmd.data = req_wdata[23:0];
        req_cmd.kind = K_PIXEL;
        addr_ok      = (req_addr[1:0] == 2'b00);
        if (req_addr < CTRL_OFF)       req_cmd.kind = K_PIXEL;
        else if (req_addr == CTRL_OFF) req_cmd.kind = K_CTRL;
        else if (req_addr == FILL_OFF) req_cmd.kind = K_FILL;
        else                           addr_ok      = 1'b0;
    end

    // Extra pointer bit separates full from empty when the indices match.
    assign fifo_empty = (wptr == rptr);
    assign fifo_full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign req_ready  = !fifo_full;
    assign push       = req_valid && req_ready && addr_ok;
    assign pop        = (state == IDLE) && !fifo_empty;
    assign head       = mem[rptr[AW-1:0]];
    assign busy       = !fifo_empty || (state != IDLE);

    always_ff @(posedge clock) begin
        if (push) mem[wptr[AW-1:0]] <= req_cmd;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr    <= '0;
            rptr    <= '0;
            req_err <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            req_err <= req_valid && req_ready && !addr_ok;
        end
    end

    // Commands are only popped in IDLE, so a FILL queued behind a sweep
    // cannot alter the colour of the sweep already running.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            fb_valid     <= 1'b0;
            fb_operation <= 1'b0;
            fb_dump      <= 1'b0;
            fb_address   <= '0;
            fb_data      <= '0;
            fill_color   <= '0;
            sweep_dump   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (!fifo_empty) begin
                    case (head.kind)
                        K_PIXEL: begin
                            state        <= ISSUE;
                            fb_valid     <= 1'b1;
                            fb_operation <= 1'b1;
                            fb_address   <= head.idx;
                            fb_data      <= head.data;
                        end
                        K_FILL: fill_color <= head.data;
                        K_CTRL: begin
                            if (head.data[1]) begin
                                state        <= SWEEP;
                                sweep_dump   <= head.data[0];
                                fb_valid     <= 1'b1;
                                fb_operation <= 1'b1;
                                fb_address   <= '0;
                                fb_data      <= fill_color;
                            end else if (head.data[0]) begin
                                state      <= DUMP;
                                fb_valid   <= 1'b1;
                                fb_dump    <= 1'b1;
                                fb_address <= '0;
                                fb_data    <= '0;
                            end
                        end
                        default: ;
                    endcase
                end
                ISSUE: if (fb_ready) begin
                    state        <= IDLE;
                    fb_valid     <= 1'b0;
                    fb_operation <= 1'b0;
                end
                SWEEP: if (fb_ready) begin
                    if (fb_address == LAST_IDX) begin
                        fb_operation <= 1'b0;
                        fb_address   <= '0;
                        if (sweep_dump) begin
                            state   <= DUMP;
                            fb_dump <= 1'b1;
                            fb_data <= '0;
                        end else begin
                            state    <= IDLE;
                            fb_valid <= 1'b0;
                        end
                    end else begin
                        fb_address <= fb_address + 1'b1;
                    end
                end
                DUMP: if (fb_ready) begin
                    state    <= IDLE;
                    fb_valid <= 1'b0;
                    fb_dump  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fb_write_bridge.sv
// Directed bench for fb_write_bridge at default frame size; inputs driven and
// outputs sampled on the falling clock edge.
module tb_fb_write_bridge;
    localparam int NPIX = 320 * 240;
    localparam int FD   = 4;

    logic        clock, reset, req_valid, req_ready, req_err, busy;
    logic        fb_valid, fb_ready, fb_operation, fb_dump;
    logic [19:0] req_addr;
    logic [31:0] req_wdata;
    logic [16:0] fb_address;
    logic [23:0] fb_data;
    int          checks = 0;
    int          errors = 0;

    fb_write_bridge #(.FRAME_WIDTH(320), .FRAME_HEIGHT(240), .FIFO_DEPTH(FD)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_err(req_err), .busy(busy),
        .fb_valid(fb_valid), .fb_ready(fb_ready), .fb_address(fb_address),
        .fb_data(fb_data), .fb_operation(fb_operation), .fb_dump(fb_dump)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Called on a falling edge with req_ready high; returns one falling edge later.
    task automatic do_store(input logic [19:0] a, input logic [31:0] d);
        req_valid = 1'b1; req_addr = a; req_wdata = d;
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0; req_valid = 1'b0; fb_ready = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clock);
        checks++;
        if ({fb_valid, fb_operation, fb_dump, req_err, busy, req_ready} !== 6'b000001) begin
            errors++; $display("FAIL reset_ctrl got %b want 000001",
                {fb_valid, fb_operation, fb_dump, req_err, busy, req_ready});
        end
        checks++;
        if (fb_address !== 17'd0 || fb_data !== 24'd0) begin
            errors++; $display("FAIL reset_payload got addr %0d data %h want 0 0", fb_address, fb_data);
        end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_single_pixel;
        fb_ready = 1'b1;
        do_store(20'h00008, 32'h00123456);
        checks++;
        if (fb_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL pix_pop_cycle got valid %b busy %b want 0 1", fb_valid, busy);
        end
        @(negedge clock);
        checks++;
        if ({fb_valid, fb_operation, fb_dump} !== 3'b110) begin
            errors++; $display("FAIL pix_beat_flags got %b want 110", {fb_valid, fb_operation, fb_dump});
        end
        checks++;
        if (fb_address !== 17'd2 || fb_data !== 24'h123456) begin
            errors++; $display("FAIL pix_beat_payload got %0d %h want 2 123456", fb_address, fb_data);
        end
        @(negedge clock);
        checks++;
        if (fb_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL pix_done got valid %b busy %b want 0 0", fb_valid, busy);
        end
    endtask

    task automatic test_backpressure;
        int n_acc, n_beat;
        n_acc = 0; n_beat = 0;
        fb_ready = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc == 12) begin
                // One entry already sits in the stalled output beat, the rest fill the FIFO.
                checks++;
                if (n_acc !== FD + 1 || req_ready !== 1'b0) begin
                    errors++; $display("FAIL bp_full got acc %0d ready %b want %0d 0", n_acc, req_ready, FD + 1);
                end
                checks++;
                if (fb_valid !== 1'b1 || fb_address !== 17'd64 || fb_data !== 24'hA00000) begin
                    errors++; $display("FAIL bp_hold got v %b %0d %h want 1 64 a00000", fb_valid, fb_address, fb_data);
                end
                fb_ready = 1'b1;
            end
            if (fb_valid && fb_ready) begin
                checks++;
                if (fb_address !== 17'(64 + n_beat) || fb_data !== 24'(24'hA00000 + n_beat) ||
                    fb_operation !== 1'b1 || fb_dump !== 1'b0) begin
                    errors++; $display("FAIL bp_order beat %0d got %0d %h want %0d %h", n_beat,
                        fb_address, fb_data, 64 + n_beat, 24'hA00000 + n_beat);
                end
                n_beat++;
            end
            req_valid = (n_acc < 6);
            req_addr  = 20'(256 + n_acc * 4);
            req_wdata = 32'(32'h00A00000 + n_acc);
            if (req_valid && req_ready) n_acc++;
            @(negedge clock);
        end
        req_valid = 1'b0;
        checks++;
        if (n_beat !== 6 || busy !== 1'b0) begin
            errors++; $display("FAIL bp_drain got beats %0d busy %b want 6 0", n_beat, busy);
        end
    endtask

    task automatic test_invalid;
        fb_ready = 1'b1;
        do_store(20'h4B008, 32'h11111111);
        checks++;
        if ({req_err, fb_valid} !== 2'b10) begin
            errors++; $display("FAIL err_range got err/valid %b want 10", {req_err, fb_valid});
        end
        @(negedge clock);
        checks++;
        if ({req_err, fb_valid} !== 2'b00) begin
            errors++; $display("FAIL err_range_pulse got %b want 00", {req_err, fb_valid});
        end
        do_store(20'h00002, 32'h22222222);
        checks++;
        if ({req_err, fb_valid} !== 2'b10) begin
            errors++; $display("FAIL err_align got err/valid %b want 10", {req_err, fb_valid});
        end
        repeat (3) @(negedge clock);
        checks++;
        if ({req_err, fb_valid, busy} !== 3'b000) begin
            errors++; $display("FAIL err_quiet got %b want 000", {req_err, fb_valid, busy});
        end
    endtask

    task automatic test_fill_sweep;
        int n_pix, n_dump, bad, both, extra, cyc;
        n_pix = 0; n_dump = 0; bad = 0; both = 0; extra = 0; cyc = 0;
        fb_ready = 1'b1;
        do_store(20'h4B004, 32'h00FF00FF);
        do_store(20'h4B000, 32'h00000003);
        while (n_dump == 0 && cyc < 80000) begin
            if (fb_valid) begin
                if (fb_operation && fb_dump) both++;
                if (fb_operation) begin
                    if (fb_address !== 17'(n_pix) || fb_data !== 24'hFF00FF) bad++;
                    n_pix++;
                end else if (fb_dump) begin
                    if (n_pix != NPIX || fb_data !== 24'd0) bad++;
                    n_dump++;
                end
            end
            @(negedge clock);
            cyc++;
        end
        repeat (4) begin
            if (fb_valid) extra++;
            @(negedge clock);
        end
        checks++;
        if (n_pix !== NPIX || bad !== 0 || both !== 0) begin
            errors++; $display("FAIL sweep_seq got pix %0d bad %0d both %0d want %0d 0 0", n_pix, bad, both, NPIX);
        end
        checks++;
        if (n_dump !== 1 || extra !== 0) begin
            errors++; $display("FAIL sweep_dump got dumps %0d extra %0d want 1 0", n_dump, extra);
        end
        checks++;
        if (cyc > NPIX + 8 || busy !== 1'b0) begin
            errors++; $display("FAIL sweep_rate got cycles %0d busy %b want <=%0d 0", cyc, busy, NPIX + 8);
        end
    endtask

    task automatic test_stall_sweep_reset;
        logic        prev_v, prev_r, hit;
        logic [16:0] prev_a;
        logic [23:0] prev_d;
        int          unstable, gaps, wrong_col, quiet;
        prev_v = 1'b0; prev_r = 1'b0; hit = 1'b0; prev_a = '0; prev_d = '0;
        unstable = 0; gaps = 0; wrong_col = 0; quiet = 0;
        do_store(20'h4B000, 32'h00000002);
        for (int cyc = 0; cyc < 6000 && !hit; cyc++) begin
            if (prev_v && !prev_r &&
                {fb_valid, fb_address, fb_data, fb_operation, fb_dump} !== {1'b1, prev_a, prev_d, 2'b10})
                unstable++;
            if (prev_v && prev_r && fb_valid && fb_address !== prev_a + 17'd1) gaps++;
            if (fb_valid && fb_data !== 24'hFF00FF) wrong_col++;
            if (fb_valid && fb_address == 17'd1000) hit = 1'b1;
            else begin
                prev_v   = fb_valid; prev_a = fb_address; prev_d = fb_data;
                fb_ready = 1'($urandom_range(0, 1));
                prev_r   = fb_ready;
                // A FILL and a pixel queued mid-sweep must wait and not recolour it.
                req_valid = (cyc == 5 || cyc == 6);
                req_addr  = (cyc == 5) ? 20'h4B004 : 20'h00010;
                req_wdata = 32'h0000FF00;
                @(negedge clock);
            end
        end
        req_valid = 1'b0;
        reset = 1'b0;
        #1;
        checks++;
        if ({fb_valid, fb_operation, fb_dump, busy, req_ready} !== 5'b00001 || fb_address !== 17'd0) begin
            errors++; $display("FAIL rst_async got %b addr %0d want 00001 0",
                {fb_valid, fb_operation, fb_dump, busy, req_ready}, fb_address);
        end
        checks++;
        if (hit !== 1'b1 || unstable !== 0 || gaps !== 0 || wrong_col !== 0) begin
            errors++; $display("FAIL stall_sweep got hit %b unstable %0d gaps %0d colour %0d want 1 0 0 0",
                hit, unstable, gaps, wrong_col);
        end
        @(negedge clock);
        reset = 1'b1; fb_ready = 1'b1;
        repeat (10) begin
            @(negedge clock);
            if (fb_valid || busy) quiet++;
        end
        checks++;
        if (quiet !== 0) begin
            errors++; $display("FAIL rst_drop got %0d active cycles want 0", quiet);
        end
        do_store(20'h4B000, 32'h00000002);
        @(negedge clock);
        checks++;
        if (fb_valid !== 1'b1 || fb_address !== 17'd0 || fb_data !== 24'd0) begin
            errors++; $display("FAIL rst_fill_color got v %b %0d %h want 1 0 000000", fb_valid, fb_address, fb_data);
        end
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_backpressure();
        test_invalid();
        test_fill_sweep();
        test_stall_sweep_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
